// File: rtl/audio_fx_scheduler_if.sv
// Audio scheduler bus: effect triggers, ROM address/data pairs and the mixed codec word.
// The master side is the scheduler; the slave side is the game logic, ROMs and codec.
interface audio_fx_scheduler_if #(
    parameter int unsigned BG_AW = 19,
    parameter int unsigned FX_AW = 16
);
    logic [3:0]        req;
    logic              bg_en;
    logic [BG_AW-1:0]  bg_addr;
    logic [FX_AW+1:0]  fx_addr;
    logic signed [5:0] bg_sample;
    logic signed [5:0] fx_sample;
    logic signed [31:0] sound;
    logic              busy;
    logic [1:0]        fx_sel;
    logic              done;

    modport master (
        input  req, bg_en, bg_sample, fx_sample,
        output bg_addr, fx_addr, sound, busy, fx_sel, done
    );

    modport slave (
        output req, bg_en, bg_sample, fx_sample,
        input  bg_addr, fx_addr, sound, busy, fx_sel, done
    );
endinterface

// File: rtl/audio_fx_scheduler.sv
// Sample-rate scheduler for four prioritised sound effects plus a looping background track.
// Define AUDIO_FX_PREEMPT_EN to let a higher-priority request abort the playing effect.
module audio_fx_scheduler #(
    parameter int unsigned DIV    = 1134,
    parameter int unsigned BG_AW  = 19,
    parameter int unsigned BG_LEN = 377974,
    parameter int unsigned FX_AW  = 16,
    parameter int unsigned LEN0   = 48279,
    parameter int unsigned LEN1   = 48279,
    parameter int unsigned LEN2   = 48279,
    parameter int unsigned LEN3   = 48279
) (
    input logic                  CLOCK_50,
    input logic                  reset,
    audio_fx_scheduler_if.master bus
);
    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [FX_AW:0] L0 = (FX_AW+1)'(LEN0);
    localparam logic [FX_AW:0] L1 = (FX_AW+1)'(LEN1);
    localparam logic [FX_AW:0] L2 = (FX_AW+1)'(LEN2);
    localparam logic [FX_AW:0] L3 = (FX_AW+1)'(LEN3);

    typedef enum logic [1:0] {StIdle, StLoad, StPlay} state_e;

    state_e            state;
    logic [CW-1:0]     tick_cnt;
    logic              tick;
    logic [3:0]        req_q, req_edge, pending, clr;
    logic [1:0]        pick, fx_sel;
    logic              preempt, done;
    logic [FX_AW-1:0]  offset;
    logic [FX_AW:0]    len;
    logic [BG_AW-1:0]  bg_addr;
    logic              bg_act_d, fx_act_d;
    logic signed [6:0] bg_ext, fx_ext, mix;
    logic signed [31:0] sound;

    function automatic logic [FX_AW:0] len_of(input logic [1:0] sel);
        unique case (sel)
            2'd0: return L0;
            2'd1: return L1;
            2'd2: return L2;
            2'd3: return L3;
        endcase
    endfunction

    always_comb begin
        tick     = (tick_cnt == CW'(DIV - 1));
        req_edge = bus.req & ~req_q;
        pick     = pending[0] ? 2'd0 : pending[1] ? 2'd1 : pending[2] ? 2'd2 : 2'd3;
`ifdef AUDIO_FX_PREEMPT_EN
        // pick is the lowest pending index, so pick < fx_sel means a higher priority waits
        preempt = (state == StPlay) && (|pending) && (pick < fx_sel);
`else
        preempt = 1'b0;
`endif
        clr = 4'b0000;
        if (((state == StIdle) && (|pending)) || preempt) clr = 4'b0001 << pick;
        bg_ext = bg_act_d ? {bus.bg_sample[5], bus.bg_sample} : 7'sd0;
        fx_ext = fx_act_d ? {bus.fx_sample[5], bus.fx_sample} : 7'sd0;
        mix    = bg_ext + fx_ext;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
            req_q    <= '0;
            pending  <= '0;
            bg_addr  <= '0;
            bg_act_d <= 1'b0;
            fx_act_d <= 1'b0;
            sound    <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + CW'(1);
            req_q    <= bus.req;
            // a fresh edge wins over a same-cycle clear so retriggers are never lost
            pending  <= (pending & ~clr) | req_edge;
            if (bus.bg_en && tick) begin
                bg_addr <= (bg_addr == BG_AW'(BG_LEN - 1)) ? '0 : bg_addr + BG_AW'(1);
            end
            bg_act_d <= bus.bg_en;
            fx_act_d <= (state == StPlay);
            sound    <= {mix, 25'b0};
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state  <= StIdle;
            fx_sel <= 2'd0;
            offset <= '0;
            len    <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (|pending) begin
                        fx_sel <= pick;
                        offset <= '0;
                        state  <= StLoad;
                    end
                end
                StLoad: begin
                    offset <= '0;
                    len    <= len_of(fx_sel);
                    state  <= StPlay;
                end
                StPlay: begin
                    if (preempt) begin
                        fx_sel <= pick;
                        offset <= '0;
                        state  <= StLoad;
                    end else if (tick) begin
                        if ({1'b0, offset} == len - (FX_AW+1)'(1)) begin
                            done  <= 1'b1;
                            state <= StIdle;
                        end else begin
                            offset <= offset + FX_AW'(1);
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.bg_addr = bg_addr;
    assign bus.fx_addr = {fx_sel, offset};
    assign bus.sound   = sound;
    assign bus.busy    = (state != StIdle);
    assign bus.fx_sel  = fx_sel;
    assign bus.done    = done;
endmodule

// File: tb/tb_audio_fx_scheduler.sv
// Directed bench for audio_fx_scheduler with DIV=4, BG_LEN=5 and short effects (2,3,2,2).
// Ticks land on posedges whose count since reset release is a multiple of 4.
module tb_audio_fx_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   c;

    always #5 clk = ~clk;

    audio_fx_scheduler_if #(.BG_AW(19), .FX_AW(16)) bus ();

    audio_fx_scheduler #(
        .DIV(4), .BG_AW(19), .BG_LEN(5), .FX_AW(16),
        .LEN0(2), .LEN1(3), .LEN2(2), .LEN3(2)
    ) dut (
        .CLOCK_50(clk),
        .reset(rst),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic to(input int t);
        while (cyc < t) step();
    endtask

    task automatic align();
        while (cyc % 4 != 1) step();
    endtask

    task automatic pulse(input logic [3:0] v);
        bus.req = v;
        step();
        bus.req = 4'b0000;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".bg_addr"}, 32'(bus.bg_addr), 32'h0);
        chk({tag, ".fx_addr"}, 32'(bus.fx_addr), 32'h0);
        chk({tag, ".sound"}, bus.sound, 32'h0);
        chk({tag, ".busy"}, 32'(bus.busy), 32'h0);
        chk({tag, ".fx_sel"}, 32'(bus.fx_sel), 32'h0);
        chk({tag, ".done"}, 32'(bus.done), 32'h0);
    endtask

    initial begin
        bus.req = 4'b0000;
        bus.bg_en = 1'b0;
        bus.bg_sample = 6'sd0;
        bus.fx_sample = 6'sd0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        cyc = 0;

        // background wrap and mute
        bus.bg_en = 1'b1;
        bus.bg_sample = 6'sd5;
        to(3);  chk("bg_addr@3", 32'(bus.bg_addr), 32'd0);
        to(4);  chk("bg_addr@4", 32'(bus.bg_addr), 32'd1);
        to(8);  chk("bg_addr@8", 32'(bus.bg_addr), 32'd2);
        to(10); chk("bg_sound", bus.sound, 32'h0A00_0000);
        to(12); chk("bg_addr@12", 32'(bus.bg_addr), 32'd3);
        to(16); chk("bg_addr@16", 32'(bus.bg_addr), 32'd4);
        to(20); chk("bg_wrap", 32'(bus.bg_addr), 32'd0);
        to(24); chk("bg_addr@24", 32'(bus.bg_addr), 32'd1);
        to(25); bus.bg_en = 1'b0;
        to(26); chk("mute_lag1", bus.sound, 32'h0A00_0000);
        to(27); chk("mute_lag2", bus.sound, 32'h0);
        to(28); chk("bg_hold@28", 32'(bus.bg_addr), 32'd1);
        to(32); chk("bg_hold@32", 32'(bus.bg_addr), 32'd1);

        // single effect 1, length 3
        bus.fx_sample = 6'sd31;
        align(); c = cyc;
        pulse(4'b0010);
        chk("single.idle_n1", 32'(bus.busy), 32'd0);
        to(c + 2);  chk("single.load_busy", 32'(bus.busy), 32'd1);
                    chk("single.addr0", 32'(bus.fx_addr), 32'h10000);
        to(c + 4);  chk("single.sound_lag", bus.sound, 32'h0);
        to(c + 5);  chk("single.sound", bus.sound, 32'h3E00_0000);
        to(c + 6);  chk("single.addr0_hold", 32'(bus.fx_addr), 32'h10000);
        to(c + 7);  chk("single.addr1", 32'(bus.fx_addr), 32'h10001);
        to(c + 11); chk("single.addr2", 32'(bus.fx_addr), 32'h10002);
        to(c + 14); chk("single.last_busy", 32'(bus.busy), 32'd1);
                    chk("single.no_early_done", 32'(bus.done), 32'd0);
        to(c + 15); chk("single.done", 32'(bus.done), 32'd1);
                    chk("single.done_sel", 32'(bus.fx_sel), 32'd1);
                    chk("single.done_idle", 32'(bus.busy), 32'd0);
        to(c + 16); chk("single.done_pulse", 32'(bus.done), 32'd0);
                    chk("single.stay_idle", 32'(bus.busy), 32'd0);
        to(c + 17); chk("single.sound_off", bus.sound, 32'h0);

        // simultaneous requests 1 and 3, with the mix extremes
        bus.bg_en = 1'b1;
        bus.bg_sample = 6'sd31;
        align(); c = cyc;
        pulse(4'b1010);
        to(c + 2);  chk("simul.first_sel", 32'(bus.fx_sel), 32'd1);
        to(c + 5);  chk("mix.max", bus.sound, 32'h7C00_0000);
        to(c + 6);  bus.bg_sample = -6'sd32; bus.fx_sample = -6'sd32;
        to(c + 7);  chk("mix.min", bus.sound, 32'h8000_0000);
        to(c + 15); chk("simul.done1", 32'(bus.done), 32'd1);
                    chk("simul.done1_sel", 32'(bus.fx_sel), 32'd1);
        to(c + 16); chk("simul.load3_sel", 32'(bus.fx_sel), 32'd3);
                    chk("simul.load3_addr", 32'(bus.fx_addr), 32'h30000);
                    chk("simul.load3_busy", 32'(bus.busy), 32'd1);
        to(c + 19); chk("simul.addr3_1", 32'(bus.fx_addr), 32'h30001);
        to(c + 22); chk("simul.no_done2_yet", 32'(bus.done), 32'd0);
        to(c + 23); chk("simul.done2", 32'(bus.done), 32'd1);
                    chk("simul.done2_sel", 32'(bus.fx_sel), 32'd3);
        to(c + 24); chk("simul.idle", 32'(bus.busy), 32'd0);

        // retrigger effect 2 during its own playback
        align(); c = cyc;
        pulse(4'b0100);
        to(c + 4);  pulse(4'b0100);
        to(c + 11); chk("retrig.done1", 32'(bus.done), 32'd1);
                    chk("retrig.done1_sel", 32'(bus.fx_sel), 32'd2);
        to(c + 12); chk("retrig.reload", 32'(bus.fx_addr), 32'h20000);
                    chk("retrig.reload_busy", 32'(bus.busy), 32'd1);
        to(c + 15); chk("retrig.addr1", 32'(bus.fx_addr), 32'h20001);
        to(c + 19); chk("retrig.done2", 32'(bus.done), 32'd1);
                    chk("retrig.done2_sel", 32'(bus.fx_sel), 32'd2);
        to(c + 20); chk("retrig.idle", 32'(bus.busy), 32'd0);

        // request 0 arriving while effect 3 plays
        align(); c = cyc;
        pulse(4'b1000);
        to(c + 4);  pulse(4'b0001);
`ifdef AUDIO_FX_PREEMPT_EN
        to(c + 6);  chk("preempt.sel", 32'(bus.fx_sel), 32'd0);
                    chk("preempt.addr", 32'(bus.fx_addr), 32'h00000);
                    chk("preempt.busy", 32'(bus.busy), 32'd1);
        to(c + 11); chk("preempt.no_done3", 32'(bus.done), 32'd0);
                    chk("preempt.addr1", 32'(bus.fx_addr), 32'h00001);
        to(c + 15); chk("preempt.done0", 32'(bus.done), 32'd1);
                    chk("preempt.done0_sel", 32'(bus.fx_sel), 32'd0);
`else
        to(c + 10); chk("wait.still3", 32'(bus.fx_sel), 32'd3);
                    chk("wait.addr3_1", 32'(bus.fx_addr), 32'h30001);
        to(c + 11); chk("wait.done3", 32'(bus.done), 32'd1);
                    chk("wait.done3_sel", 32'(bus.fx_sel), 32'd3);
        to(c + 12); chk("wait.load0", 32'(bus.fx_sel), 32'd0);
                    chk("wait.load0_busy", 32'(bus.busy), 32'd1);
        to(c + 19); chk("wait.done0", 32'(bus.done), 32'd1);
                    chk("wait.done0_sel", 32'(bus.fx_sel), 32'd0);
`endif
        to(c + 21);

        // asynchronous reset in the middle of playback
        align(); c = cyc;
        pulse(4'b0010);
        to(c + 8);  chk("rst.playing", 32'(bus.busy), 32'd1);
                    chk("rst.addr_pre", 32'(bus.fx_addr), 32'h10001);
        #2 rst = 1'b1;
        #1 chk_all_zero("rst.mid");
        @(posedge clk);
        #1 rst = 1'b0;
        cyc = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rst.no_done", 32'(bus.done), 32'd0);
        end
        chk("rst.stays_idle", 32'(bus.busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/audio_fx_scheduler.md
# audio_fx_scheduler

Sequences sound-effect playback for the game's audio path. It captures trigger pulses from up to four game events and arbitrates them by fixed priority. It steps the background-loop ROM and the effect ROM at the audio sample rate and mixes both channels into the 32-bit `sound` word for the audio codec interface. It replaces the per-effect ad-hoc enable and counter logic with one scheduler that owns the sample-rate tick, both ROM address counters and the mix.

## Interface
Parameters:
- `DIV`, 1134: clock cycles per sample tick (50 MHz / 1134 ≈ 44.1 kHz).
- `BG_AW`, 19: background ROM address width.
- `BG_LEN`, 377974: background loop length in samples.
- `FX_AW`, 16: per-effect segment address width.
- `LEN0`..`LEN3`, 48279 (each): effect lengths in samples. Each is ≥1 and ≤2^FX_AW.

Ports:
- `CLOCK_50`, in, 1: the single clock.
- `reset`, in, 1: asynchronous, active-high.
- `req`, in, 4: effect trigger lines. A rising edge requests that effect. Bit 0 has the highest priority.
- `bg_en`, in, 1: background loop run/mute.
- `bg_addr`, out, BG_AW: background ROM address.
- `fx_addr`, out, FX_AW+2: effect ROM address {`fx_sel`, offset}.
- `bg_sample`, in, 6 (signed): background ROM data. Valid one cycle after the address.
- `fx_sample`, in, 6 (signed): effect ROM data. Valid one cycle after the address.
- `sound`, out, 32 (signed): mixed output.
- `busy`, out, 1: an effect is loading or playing.
- `fx_sel`, out, 2: index of the current or last effect.
- `done`, out, 1: one-cycle pulse when an effect completes.

## Operation
- **Tick:** a free-running counter runs 0..DIV-1. `tick` is high for one cycle when the count is DIV-1. The counter restarts at 0 after reset.
- **Edge capture:** `req` is registered into `req_q`. `edge = req & ~req_q`. `pending |= edge`.
  - If an edge sets a pending bit in the same cycle the scheduler clears that bit, the set wins.
  - A request for the effect currently playing is latched and replays after it finishes.
- **Background channel:**
  - With `bg_en` = 1: `bg_addr` advances on `tick` and wraps from BG_LEN-1 to 0.
  - With `bg_en` = 0: `bg_addr` holds and the background channel is muted.
- **FSM (IDLE, LOAD, PLAY):**
  - IDLE: if `pending` ≠ 0, set `fx_sel` to the lowest set index, clear that pending bit, and go to LOAD.
  - LOAD: set the offset to 0, latch `len` = LEN[`fx_sel`], and go to PLAY. LOAD lasts exactly 1 cycle.
  - PLAY: on `tick`, if offset = `len`-1, pulse `done` and go to IDLE; otherwise increment the offset. The offset holds between ticks.
- **Active flags:**
  - `fx_act` = (state == PLAY).
  - `bg_act` = `bg_en`.
  - Both flags are delayed one cycle to align with ROM latency.
- **Mix:** the signed 7-bit sum is `s` = (`bg_act_d` ? `bg_sample` : 0) + (`fx_act_d` ? `fx_sample` : 0), each operand sign-extended. `sound` is registered every cycle as {`s`, 25'b0}. The sum cannot overflow.
- `busy` = (state ≠ IDLE).

## Timing
- **Reset values:** every output is 0. Also reset to 0: `pending`, `req_q`, the tick counter, offset and `len`; the state is IDLE. Reset is asynchronous and takes effect mid-playback with no `done` pulse.
- **Latency:**
  - `req` edge at cycle n: `pending` is set at n+1 (n+2 counting the `req_q` register); IDLE→LOAD at n+2; PLAY from n+3.
  - The first sample address (offset 0) is presented from LOAD onward.
  - Offsets advance only on ticks.
- **Playback length:** an effect with length L occupies exactly L ticks in PLAY. Offset L-1 remains presented until the final tick.
- **`done` and back-to-back effects:** `done` is asserted in the cycle after the final tick and `fx_sel` stays stable through it. The next pending effect enters LOAD on the cycle after `done`.
- **`sound` latency:** `sound` lags its address by 2 cycles (1 ROM cycle plus 1 mix register).
- **Simultaneous edges:** all edges are latched and are served in index order, one after another.

## Configuration
- **Macro:** `AUDIO_FX_PREEMPT_EN`.
- **Defined:**
  - In PLAY, if any pending bit has an index lower than `fx_sel`, the current effect aborts on the next cycle with no `done` pulse. The FSM enters LOAD with the new `fx_sel` and clears that pending bit.
  - The aborted effect is dropped, not re-queued.
- **Undefined:** no preemption. Pending requests wait until `done`.

## Test plan
- **Single effect:** DIV=4, LEN1=3, pulse `req[1]`. Expect:
  - PLAY for 3 ticks (12 cycles).
  - `fx_addr` = 0x10000, 0x10001, 0x10002.
  - `done` pulses once with `fx_sel`=1, then `busy`=0.
- **Simultaneous requests:** pulse `req` = 4'b1010 in one cycle. Expect effect 1 then effect 3 back-to-back, with two `done` pulses, `fx_sel` 1 then 3, and no idle gap beyond the LOAD cycle.
- **Background wrap and mute:**
  - BG_LEN=5 with `bg_en`=1: `bg_addr` runs 0,1,2,3,4,0.
  - Drop `bg_en`: the address holds.
  - With `fx` idle and `bg_en`=0, `sound` = 0 two cycles later.
- **Mix arithmetic:** `bg_sample`=31, `fx_sample`=31 with both channels active: `sound` = {7'd62, 25'b0}. With -32 and -32: `sound` = {7'b1000000, 25'b0}.
- **Retrigger:** re-pulse `req[2]` during its own playback. It finishes, then replays from offset 0 with a second `done`.
- **Preemption and reset:**
  - With `AUDIO_FX_PREEMPT_EN` defined, pulse `req[0]` while effect 3 plays: no `done` for effect 3, and effect 0 starts within 3 cycles.
  - Assert `reset` mid-PLAY: all outputs read 0 immediately.
